// File: rtl/axi_rd_segment_guard_if.sv
// AXI read-channel bundle (AR + R) shared by the upstream and downstream
// sides of the segment guard. The "master" modport drives requests and
// accepts read data; the "slave" modport is the mirror image.
interface axi_rd_segment_guard_if #(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_segment_guard.sv
// AXI read segment guard: accepts one read request at a time, forwards it
// downstream with an address translation when the start address falls in
// [SEG_BASE, SEG_BASE+SEG_SIZE), otherwise answers locally with a DECERR
// burst of arlen+1 beats. R data is passed through combinationally.
module axi_rd_segment_guard #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    ID_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] SEG_BASE   = 32'h1000_0000,
  parameter logic [ADDR_WIDTH-1:0] SEG_SIZE   = 32'h1000_0000,
  parameter logic [ADDR_WIDTH-1:0] SEG_OFFSET = '0
) (
  input  logic                    axi_clk,
  input  logic                    axi_rst,
  axi_rd_segment_guard_if.slave   s_axi,
  axi_rd_segment_guard_if.master  m_axi
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    AR_OUT = 2'd1,
    R_FWD  = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]            len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  hit_q, hit_d;
  logic                  arready_q, arready_d;

  // Extra top bit keeps the range compare free of wrap-around.
  logic [ADDR_WIDTH:0]   addr_ext;
  logic [ADDR_WIDTH:0]   base_ext;
  logic [ADDR_WIDTH:0]   size_ext;
  logic [ADDR_WIDTH:0]   diff_ext;
  logic                  req_hit;
  logic [ADDR_WIDTH-1:0] req_xlate;

  // Segment decode and address translation of the incoming start address.
  always_comb begin
    addr_ext  = {1'b0, s_axi.araddr};
    base_ext  = {1'b0, SEG_BASE};
    size_ext  = {1'b0, SEG_SIZE};
    diff_ext  = addr_ext - base_ext;
    req_hit   = (addr_ext >= base_ext) && (diff_ext < size_ext);
    req_xlate = s_axi.araddr - SEG_BASE + SEG_OFFSET;
  end

  // Next-state logic and all channel outputs.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    id_d       = id_q;
    len_d      = len_q;
    addr_d     = addr_q;
    hit_d      = hit_q;

    s_axi.arready = arready_q;
    s_axi.rvalid  = 1'b0;
    s_axi.rid     = {ID_WIDTH{1'b0}};
    s_axi.rdata   = {DATA_WIDTH{1'b0}};
    s_axi.rresp   = 2'b00;
    s_axi.rlast   = 1'b0;

    m_axi.arvalid = 1'b0;
    m_axi.arid    = id_q;
    m_axi.araddr  = addr_q;
    m_axi.arlen   = len_q;
    m_axi.rready  = 1'b0;

    case (state_q)
      IDLE: begin
        if (s_axi.arvalid && arready_q) begin
          id_d       = s_axi.arid;
          len_d      = s_axi.arlen;
          addr_d     = req_xlate;
          hit_d      = req_hit;
          beat_cnt_d = 8'd0;
          state_d    = req_hit ? AR_OUT : ERR;
        end else begin
          state_d = IDLE;
        end
      end
      AR_OUT: begin
        m_axi.arvalid = hit_q;
        if (m_axi.arready) begin
          state_d = R_FWD;
        end else begin
          state_d = AR_OUT;
        end
      end
      R_FWD: begin
        s_axi.rvalid = m_axi.rvalid;
        s_axi.rid    = m_axi.rid;
        s_axi.rdata  = m_axi.rdata;
        s_axi.rresp  = m_axi.rresp;
        s_axi.rlast  = m_axi.rlast;
        m_axi.rready = s_axi.rready;
        if (m_axi.rvalid && s_axi.rready && m_axi.rlast) begin
          state_d = IDLE;
        end else begin
          state_d = R_FWD;
        end
      end
      ERR: begin
        s_axi.rvalid = 1'b1;
        s_axi.rid    = id_q;
        s_axi.rdata  = {DATA_WIDTH{1'b0}};
        s_axi.rresp  = 2'b11;
        s_axi.rlast  = (beat_cnt_q == len_q);
        if (s_axi.rready) begin
          if (beat_cnt_q == len_q) begin
            state_d = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end else begin
          state_d = ERR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Ready is registered from the next state so it reappears the cycle
    // right after the final beat and one edge after reset release.
    arready_d = (state_d == IDLE);
  end

  // State, captured request and beat counter registers.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= 8'd0;
      id_q       <= {ID_WIDTH{1'b0}};
      len_q      <= 8'd0;
      addr_q     <= {ADDR_WIDTH{1'b0}};
      hit_q      <= 1'b0;
      arready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      id_q       <= id_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      hit_q      <= hit_d;
      arready_q  <= arready_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_segment_guard.sv
// Directed testbench for axi_rd_segment_guard with default parameters.
module tb_axi_rd_segment_guard;

  logic axi_clk;
  logic axi_rst;
  int   n_assert;
  int   n_fail;
  int   beats;

  axi_rd_segment_guard_if #(.ID_WIDTH(8), .ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();
  axi_rd_segment_guard_if #(.ID_WIDTH(8), .ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();

  axi_rd_segment_guard dut (
    .axi_clk (axi_clk),
    .axi_rst (axi_rst),
    .s_axi   (s_if),
    .m_axi   (m_if)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    axi_rst  = 1'b1;
    s_if.arid = 8'h00; s_if.araddr = 32'h0; s_if.arlen = 8'd0; s_if.arvalid = 1'b0;
    s_if.rready = 1'b1;
    m_if.arready = 1'b0; m_if.rid = 8'h00; m_if.rdata = 32'h0; m_if.rresp = 2'b00;
    m_if.rlast = 1'b0; m_if.rvalid = 1'b1;

    // Reset: outputs held low even with upstream/downstream activity
    #3;
    chk("rst_arready", 64'(s_if.arready), 64'd0);
    chk("rst_arvalid", 64'(m_if.arvalid), 64'd0);
    chk("rst_rvalid",  64'(s_if.rvalid),  64'd0);
    chk("rst_rready",  64'(m_if.rready),  64'd0);
    tick();
    tick();
    chk("rst_arready_clk", 64'(s_if.arready), 64'd0);
    m_if.rvalid = 1'b0;
    @(negedge axi_clk);
    axi_rst = 1'b0;
    #1;
    chk("rel_arready_pre", 64'(s_if.arready), 64'd0);
    tick();
    chk("rel_arready_edge", 64'(s_if.arready), 64'd1);

    // Hit with 5 cycles of AR backpressure, then 4 forwarded beats
    s_if.arid = 8'h05; s_if.araddr = 32'h1000_0040; s_if.arlen = 8'd3; s_if.arvalid = 1'b1;
    tick();
    s_if.arvalid = 1'b0;
    s_if.araddr = 32'hDEAD_BEEF;
    #1;
    chk("hit_arvalid", 64'(m_if.arvalid), 64'd1);
    chk("hit_araddr",  64'(m_if.araddr),  64'h0000_0040);
    chk("hit_arlen",   64'(m_if.arlen),   64'd3);
    chk("hit_arid",    64'(m_if.arid),    64'h05);
    chk("hit_arready", 64'(s_if.arready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_arvalid", 64'(m_if.arvalid), 64'd1);
      chk("bp_araddr",  64'(m_if.araddr),  64'h0000_0040);
      chk("bp_arid",    64'(m_if.arid),    64'h05);
      chk("bp_arready", 64'(s_if.arready), 64'd0);
      chk("bp_rvalid",  64'(s_if.rvalid),  64'd0);
    end
    m_if.arready = 1'b1;
    tick();
    m_if.arready = 1'b0;
    #1;
    chk("rfwd_arvalid", 64'(m_if.arvalid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      m_if.rvalid = 1'b1;
      m_if.rid    = 8'h05;
      m_if.rdata  = 32'hA0 + 32'(i);
      m_if.rresp  = (i == 2) ? 2'b01 : 2'b00;
      m_if.rlast  = (i == 3);
      s_if.rready = 1'b0;
      #1;
      chk("fwd_rready_hold", 64'(m_if.rready), 64'd0);
      s_if.rready = 1'b1;
      #1;
      chk("fwd_rvalid", 64'(s_if.rvalid), 64'd1);
      chk("fwd_rid",    64'(s_if.rid),    64'h05);
      chk("fwd_rdata",  64'(s_if.rdata),  64'hA0 + 64'(i));
      chk("fwd_rresp",  64'(s_if.rresp),  (i == 2) ? 64'd1 : 64'd0);
      chk("fwd_rlast",  64'(s_if.rlast),  (i == 3) ? 64'd1 : 64'd0);
      chk("fwd_rready", 64'(m_if.rready), 64'd1);
      tick();
    end
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    #1;
    chk("hit_done_arready", 64'(s_if.arready), 64'd1);
    chk("hit_done_rvalid",  64'(s_if.rvalid),  64'd0);
    chk("hit_done_rready",  64'(m_if.rready),  64'd0);

    // Miss: 2 DECERR beats, nothing downstream
    s_if.arid = 8'h0A; s_if.araddr = 32'h2000_0000; s_if.arlen = 8'd1; s_if.arvalid = 1'b1;
    s_if.rready = 1'b1;
    tick();
    s_if.arvalid = 1'b0;
    #1;
    chk("miss_arvalid", 64'(m_if.arvalid), 64'd0);
    chk("miss_rvalid",  64'(s_if.rvalid),  64'd1);
    chk("miss_rid",     64'(s_if.rid),     64'h0A);
    chk("miss_rdata",   64'(s_if.rdata),   64'd0);
    chk("miss_rresp",   64'(s_if.rresp),   64'd3);
    chk("miss_rlast0",  64'(s_if.rlast),   64'd0);
    chk("miss_mrready", 64'(m_if.rready),  64'd0);
    tick();
    chk("miss_rlast1",    64'(s_if.rlast),   64'd1);
    chk("miss_rvalid1",   64'(s_if.rvalid),  64'd1);
    chk("miss_arvalid1",  64'(m_if.arvalid), 64'd0);
    tick();
    chk("miss_done_arready", 64'(s_if.arready), 64'd1);
    chk("miss_done_rvalid",  64'(s_if.rvalid),  64'd0);
    chk("miss_done_rlast",   64'(s_if.rlast),   64'd0);

    // Boundary: one below base misses
    s_if.arid = 8'h11; s_if.araddr = 32'h0FFF_FFFF; s_if.arlen = 8'd0; s_if.arvalid = 1'b1;
    tick();
    s_if.arvalid = 1'b0;
    chk("lo_arvalid", 64'(m_if.arvalid), 64'd0);
    chk("lo_rresp",   64'(s_if.rresp),   64'd3);
    chk("lo_rlast",   64'(s_if.rlast),   64'd1);
    tick();
    chk("lo_done_arready", 64'(s_if.arready), 64'd1);

    // Boundary: last byte of segment hits and maps to 0x0FFF_FFFF
    s_if.arid = 8'h22; s_if.araddr = 32'h1FFF_FFFF; s_if.arlen = 8'd0; s_if.arvalid = 1'b1;
    tick();
    s_if.arvalid = 1'b0;
    chk("hi_arvalid", 64'(m_if.arvalid), 64'd1);
    chk("hi_araddr",  64'(m_if.araddr),  64'h0FFF_FFFF);
    m_if.arready = 1'b1;
    tick();
    m_if.arready = 1'b0;
    m_if.rvalid = 1'b1; m_if.rid = 8'h22; m_if.rdata = 32'h1234_5678; m_if.rresp = 2'b10; m_if.rlast = 1'b1;
    #1;
    chk("hi_rdata", 64'(s_if.rdata), 64'h1234_5678);
    chk("hi_rresp", 64'(s_if.rresp), 64'd2);
    tick();
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    chk("hi_done_arready", 64'(s_if.arready), 64'd1);

    // Boundary: first address past the segment misses
    s_if.arid = 8'h33; s_if.araddr = 32'h2000_0000; s_if.arlen = 8'd0; s_if.arvalid = 1'b1;
    tick();
    s_if.arvalid = 1'b0;
    chk("past_arvalid", 64'(m_if.arvalid), 64'd0);
    chk("past_rvalid",  64'(s_if.rvalid),  64'd1);
    tick();

    // Miss arlen=7 with rready toggling: rlast only on the 8th beat
    beats = 0;
    s_if.arid = 8'h44; s_if.araddr = 32'h0000_1000; s_if.arlen = 8'd7; s_if.arvalid = 1'b1;
    tick();
    s_if.arvalid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      s_if.rready = (c % 2 == 1);
      #1;
      chk("tog_rvalid", 64'(s_if.rvalid), 64'd1);
      chk("tog_rlast",  64'(s_if.rlast),  (beats == 7) ? 64'd1 : 64'd0);
      if (s_if.rready) beats++;
      tick();
    end
    s_if.rready = 1'b1;
    #1;
    chk("tog_done_arready", 64'(s_if.arready), 64'd1);
    chk("tog_done_rvalid",  64'(s_if.rvalid),  64'd0);

    // Miss arlen=255: 256 beats, counter must not wrap early
    s_if.arid = 8'h55; s_if.araddr = 32'h3000_0000; s_if.arlen = 8'd255; s_if.arvalid = 1'b1;
    tick();
    s_if.arvalid = 1'b0;
    for (int b = 0; b < 256; b++) begin
      #1;
      if (b == 0 || b >= 254) begin
        chk("long_rvalid", 64'(s_if.rvalid), 64'd1);
        chk("long_rlast",  64'(s_if.rlast),  (b == 255) ? 64'd1 : 64'd0);
      end
      tick();
    end
    chk("long_done_arready", 64'(s_if.arready), 64'd1);
    chk("long_done_rvalid",  64'(s_if.rvalid),  64'd0);

    // Reset in R_FWD after 2 of 4 beats
    s_if.arid = 8'h66; s_if.araddr = 32'h1000_0100; s_if.arlen = 8'd3; s_if.arvalid = 1'b1;
    tick();
    s_if.arvalid = 1'b0;
    m_if.arready = 1'b1;
    tick();
    m_if.arready = 1'b0;
    m_if.rvalid = 1'b1; m_if.rid = 8'h66; m_if.rresp = 2'b00; m_if.rlast = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_if.rdata = 32'hB0 + 32'(i);
      tick();
    end
    #1;
    chk("mid_rvalid",  64'(s_if.rvalid), 64'd1);
    chk("mid_rready",  64'(m_if.rready), 64'd1);
    axi_rst = 1'b1;
    #1;
    chk("mid_rst_rvalid",  64'(s_if.rvalid),  64'd0);
    chk("mid_rst_rready",  64'(m_if.rready),  64'd0);
    chk("mid_rst_arready", 64'(s_if.arready), 64'd0);
    m_if.rvalid = 1'b0;
    tick();
    @(negedge axi_clk);
    axi_rst = 1'b0;
    tick();
    chk("mid_rel_arready", 64'(s_if.arready), 64'd1);
    chk("mid_rel_arvalid", 64'(m_if.arvalid), 64'd0);
    chk("mid_rel_rvalid",  64'(s_if.rvalid),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
